// File: rtl/cute_key_sequencer_pkg.sv
// cute_lock_pkg: shared types and helpers for the Cute-Lock key sequencer
package cute_lock_pkg;
  localparam int MAX_STATES = 16;
  typedef enum logic [1:0] {EMPTY, LOADING, ARMED, RUN} seq_state_t;
  function automatic logic [$clog2(MAX_STATES)-1:0] next_phase(input logic [$clog2(MAX_STATES)-1:0] ph, input logic [$clog2(MAX_STATES):0] n);
    return ({1'b0, ph} == n - 5'd1) ? 4'd0 : ph + 4'd1;
  endfunction
endpackage

// File: rtl/cute_key_sequencer_if.sv
// cute_key_sequencer_if: key-word load handshake between loader and sequencer
interface cute_key_sequencer_if #(parameter int KEY_W = 1);
  logic load_valid;
  logic load_ready;
  logic [KEY_W-1:0] load_data;
  modport master (output load_valid, output load_data, input load_ready);
  modport slave (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/cute_key_store.sv
// cute_key_store: N_STATES x KEY_W key register file, one write port, combinational read
module cute_key_store #(
  parameter int KEY_W = 1,
  parameter int N_STATES = 2,
  parameter int PH_W = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic we,
  input  logic [PH_W-1:0] widx,
  input  logic [KEY_W-1:0] wdata,
  input  logic [PH_W-1:0] ridx,
  output logic [KEY_W-1:0] rdata
);
  logic [KEY_W-1:0] mem [N_STATES];
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      for (int i = 0; i < N_STATES; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end
  assign rdata = mem[ridx];
endmodule

// File: rtl/cute_key_sequencer.sv
// cute_key_sequencer: loads one key word per lock-counter phase, then replays them in lockstep with the locked core
module cute_key_sequencer
  import cute_lock_pkg::*;
#(
  parameter int KEY_W = 1,
  parameter int N_STATES = 2,
  localparam int PH_W = N_STATES > 1 ? $clog2(N_STATES) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic start,
  input  logic stop,
  cute_key_sequencer_if.slave ld,
  output logic [KEY_W-1:0] keyinput,
  output logic key_valid,
  output logic [PH_W-1:0] phase,
  output logic armed
);
  seq_state_t state_q, state_d;
  logic [PH_W-1:0] idx_q, idx_d, phase_q, phase_d;
  logic [KEY_W-1:0] rdata;
  logic accept, last;
  assign ld.load_ready = (state_q == EMPTY) || (state_q == LOADING);
  assign accept = ld.load_valid && ld.load_ready;
  assign last = idx_q == PH_W'(N_STATES - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY, LOADING: state_d = accept ? (last ? ARMED : LOADING) : state_q;
      ARMED: state_d = (start && !stop) ? RUN : ARMED;
      RUN: state_d = stop ? ARMED : RUN;
      default: state_d = EMPTY;
    endcase
    if (clear) state_d = EMPTY;
    idx_d = clear ? '0 : accept ? idx_q + 1'b1 : idx_q;
    // phase only advances while staying in RUN; entering RUN or any other state forces 0
    phase_d = (state_q == RUN && state_d == RUN) ? PH_W'(next_phase(4'(phase_q), 5'(N_STATES))) : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      idx_q <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      phase_q <= phase_d;
    end
  end
  cute_key_store #(.KEY_W(KEY_W), .N_STATES(N_STATES), .PH_W(PH_W)) u_store (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .we(accept && !clear),
    .widx(idx_q),
    .wdata(ld.load_data),
    .ridx(phase_q),
    .rdata(rdata)
  );
  assign key_valid = state_q == RUN;
  assign armed = (state_q == ARMED) || (state_q == RUN);
  assign phase = phase_q;
  assign keyinput = key_valid ? rdata : '0;
endmodule
